// File: rtl/move_sequencer.sv
// Executes one cell move per command, then settles, debounces the wall
// sensors and pulses advance so the decision FSM sees fresh data once.
module move_sequencer #(
    parameter int STEPS_PER_CELL = 8,
    parameter int STEP_PERIOD    = 4,
    parameter int SETTLE_CYCLES  = 3,
    parameter int DEBOUNCE       = 2,
    parameter int SAMPLE_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_code,
    input  logic [3:0] sensor_raw,
    output logic [3:0] sensor_out,
    output logic       advance,
    output logic       motor_en,
    output logic [1:0] motor_dir,
    output logic       motor_step,
    output logic       busy,
    output logic       err_invalid,
    output logic       err_unstable
);

    localparam int PW = $clog2(STEP_PERIOD) + 1;
    localparam int SW = $clog2(STEPS_PER_CELL) + 1;
    localparam int TW = $clog2(SETTLE_CYCLES) + 1;
    localparam int DW = $clog2(DEBOUNCE) + 1;
    localparam int OW = $clog2(SAMPLE_TIMEOUT) + 1;

    localparam logic [PW-1:0] P_LAST   = PW'(STEP_PERIOD - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(STEPS_PER_CELL - 1);
    localparam logic [TW-1:0] SET_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] D_DONE   = DW'(DEBOUNCE);
    localparam logic [OW-1:0] O_LAST   = OW'(SAMPLE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE,
        S_SETTLE,
        S_SAMPLE,
        S_REPORT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_dir;
    logic [PW-1:0]   r_period;
    logic [SW-1:0]   r_step;
    logic [TW-1:0]   r_settle;
    logic [DW-1:0]   r_cnt;
    logic [OW-1:0]   r_timer;
    logic [3:0]      r_sample;
    logic [3:0]      r_sensor;
    logic            r_err_inv;
    logic            r_err_uns;

    logic            w_is_move;
    logic            w_is_invalid;
    logic [1:0]      w_dir;
    logic            w_accept;
    logic [DW-1:0]   w_cnt_next;
    logic            w_stable;
    logic            w_timeout;

    always_comb begin
        w_is_move = 1'b1;
        w_dir     = 2'b00;
        unique case (cmd_code)
            4'b0001: w_dir = 2'b00;
            4'b0100: w_dir = 2'b01;
            4'b0010: w_dir = 2'b10;
            4'b0011: w_dir = 2'b11;
            default: w_is_move = 1'b0;
        endcase
    end

    assign w_is_invalid = ~w_is_move & (cmd_code != 4'b0000);
    assign cmd_ready    = ~rst & (r_state == S_IDLE);
    assign w_accept     = cmd_valid & cmd_ready;

    // A zero count marks the first SAMPLE cycle, which always captures.
    assign w_cnt_next = (r_cnt == '0 || sensor_raw != r_sample)
                      ? DW'(1) : r_cnt + 1'b1;
    assign w_stable   = (w_cnt_next == D_DONE);
    assign w_timeout  = (r_timer == O_LAST);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:
                if (w_accept) w_next = w_is_move ? S_MOVE : S_SAMPLE;
            S_MOVE:
                if (r_period == P_LAST && r_step == S_LAST) w_next = S_SETTLE;
            S_SETTLE:
                if (r_settle == SET_LAST) w_next = S_SAMPLE;
            S_SAMPLE:
                if (w_stable || w_timeout) w_next = S_REPORT;
            S_REPORT:
                w_next = S_IDLE;
            default:
                w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir     <= '0;
            r_period  <= '0;
            r_step    <= '0;
            r_settle  <= '0;
            r_cnt     <= '0;
            r_timer   <= '0;
            r_sample  <= '0;
            r_sensor  <= '0;
            r_err_inv <= 1'b0;
            r_err_uns <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: if (w_accept) begin
                    r_period <= '0;
                    r_step   <= '0;
                    r_settle <= '0;
                    r_cnt    <= '0;
                    r_timer  <= '0;
                    if (w_is_move)    r_dir     <= w_dir;
                    if (w_is_invalid) r_err_inv <= 1'b1;
                end
                S_MOVE: begin
                    if (r_period == P_LAST) begin
                        r_period <= '0;
                        r_step   <= r_step + 1'b1;
                    end else begin
                        r_period <= r_period + 1'b1;
                    end
                end
                S_SETTLE: r_settle <= r_settle + 1'b1;
                S_SAMPLE: begin
                    r_cnt    <= w_cnt_next;
                    r_sample <= sensor_raw;
                    r_timer  <= r_timer + 1'b1;
                    if (w_stable || w_timeout) r_sensor  <= sensor_raw;
                    if (!w_stable && w_timeout) r_err_uns <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sensor_out   = r_sensor;
    assign advance      = (r_state == S_REPORT);
    assign motor_en     = (r_state == S_MOVE);
    assign motor_step   = (r_state == S_MOVE) && (r_period == '0);
    assign motor_dir    = r_dir;
    assign busy         = (r_state != S_IDLE);
    assign err_invalid  = r_err_inv;
    assign err_unstable = r_err_uns;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: moves, hold/invalid, debounce,
// timeout, mid-move reset and command ignore while busy.
module tb_move_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_code;
    logic [3:0] sensor_raw;
    logic [3:0] sensor_out;
    logic       advance;
    logic       motor_en;
    logic [1:0] motor_dir;
    logic       motor_step;
    logic       busy;
    logic       err_invalid;
    logic       err_unstable;

    int n_checks = 0;
    int n_err    = 0;
    int steps;
    int adv_cyc;
    int adv_seen;

    move_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_code     (cmd_code),
        .sensor_raw   (sensor_raw),
        .sensor_out   (sensor_out),
        .advance      (advance),
        .motor_en     (motor_en),
        .motor_dir    (motor_dir),
        .motor_step   (motor_step),
        .busy         (busy),
        .err_invalid  (err_invalid),
        .err_unstable (err_unstable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Presents a command in an IDLE cycle (cycle 0); returns mid cycle 1.
    task automatic accept(input logic [3:0] code);
        cmd_valid = 1'b1;
        cmd_code  = code;
        #1;
        chk("accept_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_code   = 4'b0000;
        sensor_raw = 4'b0000;
        cyc();
        cyc();
        chk("reset_outputs",
            {sensor_out, advance, motor_en, motor_dir, motor_step,
             busy, err_invalid, err_unstable}, 32'd0);
        chk("reset_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        // North move with stable sensors
        sensor_raw = 4'b1010;
        accept(4'b0001);
        steps = 0;
        for (int c = 1; c <= 39; c++) begin
            if (motor_step) steps++;
            chk($sformatf("north_c%0d", c),
                {motor_en, motor_step, advance, busy, cmd_ready},
                {c <= 32, (c <= 32) && ((c - 1) % 4 == 0),
                 c == 38, c <= 38, c >= 39});
            if (c == 1)  chk("north_dir", 32'(motor_dir), 32'd0);
            if (c == 37) chk("north_sens_pre", 32'(sensor_out), 32'd0);
            if (c == 38) chk("north_sens", 32'(sensor_out), 32'hA);
            cyc();
        end
        chk("north_steps", 32'(steps), 32'd8);

        // HOLD then invalid
        accept(4'b0000);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("hold_c%0d", c), {motor_en, advance, busy},
                {1'b0, c == 3, c <= 3});
            cyc();
        end
        chk("hold_err_inv", 32'(err_invalid), 32'd0);
        accept(4'b1111);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("inval_c%0d", c), {motor_en, advance, busy},
                {1'b0, c == 3, c <= 3});
            cyc();
        end
        chk("inval_err_inv", 32'(err_invalid), 32'd1);

        // Bouncing sensors settle on 0100 at cycle 5
        accept(4'b0000);
        for (int c = 1; c <= 8; c++) begin
            if (c <= 4) sensor_raw = (c % 2 == 1) ? 4'b0001 : 4'b0000;
            else        sensor_raw = 4'b0100;
            chk($sformatf("bounce_c%0d", c), 32'(advance), 32'(c == 7));
            if (c == 7) chk("bounce_sens", 32'(sensor_out), 32'h4);
            cyc();
        end
        chk("bounce_err_uns", 32'(err_unstable), 32'd0);

        // Timeout: toggling for all of SAMPLE
        accept(4'b0000);
        for (int c = 1; c <= 66; c++) begin
            sensor_raw = (c % 2 == 1) ? 4'b0011 : 4'b1100;
            chk($sformatf("tmo_c%0d", c), {advance, busy},
                {c == 65, c <= 65});
            cyc();
        end
        chk("tmo_sens", 32'(sensor_out), 32'hC);
        chk("tmo_err_uns", 32'(err_unstable), 32'd1);
        chk("tmo_err_inv_sticky", 32'(err_invalid), 32'd1);

        // Reset at cycle 10 of an east move
        sensor_raw = 4'b0110;
        accept(4'b0100);
        for (int c = 1; c <= 9; c++) cyc();
        chk("east_c10", {motor_en, motor_dir}, {1'b1, 2'b01});
        rst = 1'b1;
        cyc();
        chk("rst_mid_motion", {motor_en, motor_step, busy, cmd_ready}, 32'd0);
        chk("rst_mid_flags", {err_invalid, err_unstable, sensor_out}, 32'd0);
        rst = 1'b0;
        adv_seen = 0;
        for (int c = 0; c < 45; c++) begin
            if (advance) adv_seen++;
            cyc();
        end
        chk("rst_no_advance", 32'(adv_seen), 32'd0);

        // Fresh south move after reset
        accept(4'b0010);
        steps   = 0;
        adv_cyc = 0;
        for (int c = 1; c <= 39; c++) begin
            if (motor_step) steps++;
            if (advance && adv_cyc == 0) adv_cyc = c;
            if (c == 1) chk("south_dir", 32'(motor_dir), 32'd2);
            cyc();
        end
        chk("south_steps", 32'(steps), 32'd8);
        chk("south_adv_cyc", 32'(adv_cyc), 32'd38);
        chk("south_sens", 32'(sensor_out), 32'h6);

        // Busy: hold valid with changing codes across a west move
        cmd_valid = 1'b1;
        cmd_code  = 4'b0011;
        #1;
        chk("busy_accept_ready", 32'(cmd_ready), 32'd1);
        cyc();
        for (int c = 1; c <= 38; c++) begin
            cmd_code = (c % 2 == 1) ? 4'b0001 : 4'b0100;
            #1;
            chk($sformatf("busy_c%0d", c),
                {cmd_ready, motor_en, motor_dir, advance},
                {1'b0, c <= 32, 2'b11, c == 38});
            cyc();
        end
        cmd_code = 4'b0000;
        #1;
        chk("busy_c39_ready", 32'(cmd_ready), 32'd1);
        cyc();
        cmd_valid = 1'b0;
        chk("busy_next_hold", {busy, motor_en}, {1'b1, 1'b0});
        cyc();
        cyc();
        chk("busy_next_adv", 32'(advance), 32'd1);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Command executor between the maze-solving decision FSM and the drive/sensor hardware. Accepts one 4-bit movement code per handshake and drives the motor step/direction outputs for exactly one cell. It then waits a settle interval, debounces the 4-bit wall-sensor bus, and pulses `advance` so the decision FSM evaluates fresh sensor data exactly once per completed move.

## Interface
- `STEPS_PER_CELL`, default 8: motor step pulses per cell move (≥1)
- `STEP_PERIOD`, default 4: clock cycles per step pulse (≥2)
- `SETTLE_CYCLES`, default 3: wait after last step before sampling (≥1)
- `DEBOUNCE`, default 2: consecutive identical sensor samples required (≥1)
- `SAMPLE_TIMEOUT`, default 64: maximum cycles in SAMPLE (> `DEBOUNCE`)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  `cmd_code` valid
- `cmd_ready`  out  1  block accepts command; transfer when `cmd_valid & cmd_ready` at a rising edge
- `cmd_code`  in  4  movement code, `{Left,Back,Right,Front}` frame
- `sensor_raw`  in  4  unfiltered sensors `{Left,Back,Right,Front}`
- `sensor_out`  out  4  debounced, registered sensor snapshot for the decision FSM
- `advance`  out  1  one-cycle pulse: `sensor_out` updated, FSM may step
- `motor_en`  out  1  high for every cycle of MOVE
- `motor_dir`  out  2  00 north, 01 east, 10 south, 11 west
- `motor_step`  out  1  step pulse
- `busy`  out  1  high in any state other than IDLE
- `err_invalid`  out  1  sticky: unrecognised code accepted
- `err_unstable`  out  1  sticky: sample timeout occurred

## Operation
- Code map:
  - 0001 north
  - 0100 east
  - 0010 south
  - 0011 west
  - 0000 HOLD: no motion, resample only
  - any other code: invalid. Set `err_invalid` and treat as HOLD.
- States: IDLE, MOVE, SETTLE, SAMPLE, REPORT. Encoding is free.
- IDLE:
  - `cmd_ready = ~rst`.
  - On accept, latch the code.
  - Move code: go to MOVE, load `motor_dir`, clear the step and period counters.
  - HOLD or invalid code: go to SAMPLE.
- MOVE:
  - The period counter runs 0..`STEP_PERIOD`-1.
  - `motor_step`=1 exactly when period counter = 0.
  - On period = `STEP_PERIOD`-1, increment the step counter.
  - After step `STEPS_PER_CELL`-1 completes its period, go to SETTLE.
  - MOVE lasts exactly `STEPS_PER_CELL*STEP_PERIOD` cycles.
- SETTLE: lasts exactly `SETTLE_CYCLES` cycles, then go to SAMPLE.
- SAMPLE:
  - Each cycle, compare `sensor_raw` with the previously captured sample.
  - The first SAMPLE cycle sets stable count = 1.
  - Equal sample: increment the count. Different sample: set count = 1 and recapture.
  - When count reaches `DEBOUNCE`: `sensor_out <=` sample, go to REPORT.
  - If `SAMPLE_TIMEOUT` cycles elapse first: `sensor_out <=` current `sensor_raw`, set `err_unstable`, go to REPORT.
- REPORT: `advance`=1 for this single cycle, then go to IDLE.
- `cmd_valid` outside IDLE is ignored. There is no queueing, and `cmd_code` is sampled only on accept.
- Error flags clear only on `rst`.
- Counter widths are `$clog2(param)+1`. No counter may wrap within a state.

## Timing
- Reset: at the first rising edge with `rst`=1, all of the following go to 0 and the state goes to IDLE:
  - `sensor_out`, `advance`, `motor_en`, `motor_dir`, `motor_step`, `busy`, `err_invalid`, `err_unstable`
  - all counters
- `cmd_ready`=0 while `rst`=1. It returns to 1 in the first cycle after deassertion.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs except `cmd_ready` from `rst`.
- Reset mid-operation (any state): motion stops at that edge (`motor_en`/`motor_step` low), no `advance` is produced, and the command is dropped.
- Cycle numbering: the accept cycle is 0.
- Move latency with defaults:
  - MOVE: cycles 1–32
  - `motor_step` high on cycles 1, 5, …, 29
  - SETTLE: cycles 33–35
  - SAMPLE with stable sensors: cycles 36–37
  - `advance`: cycle 38
  - next accept possible: cycle 39
- General move latency: `advance` at cycle `1 + STEPS_PER_CELL*STEP_PERIOD + SETTLE_CYCLES + DEBOUNCE`.
- HOLD/invalid latency: SAMPLE on cycles 1..`DEBOUNCE`, `advance` at cycle `DEBOUNCE+1` (cycle 3 with defaults).
- `sensor_out` changes only at the edge entering REPORT. It is stable while `advance` is high.

## Test plan
- Reset then north: `rst` 2 cycles, send 0001 with `sensor_raw`=4'b1010 stable. Required:
  - exactly 8 `motor_step` pulses, period 4
  - `motor_dir`=00
  - `motor_en` high cycles 1–32
  - `advance` only at cycle 38
  - `sensor_out`=1010
  - `cmd_ready` high again at cycle 39
- HOLD and invalid: send 0000, then 1111. Required:
  - no `motor_en` for either command
  - `advance` at cycle 3 after each accept
  - `err_invalid`=0 after the first command and 1 after the second, remaining 1 until `rst`
- Bouncing sensors: toggle `sensor_raw` 0001/0000 every cycle during SAMPLE, then hold 0100. Required: `advance` 2 cycles after 0100 first appears, `sensor_out`=0100, `err_unstable`=0.
- Timeout: toggle `sensor_raw` every cycle for the whole of SAMPLE. Required: REPORT after 64 SAMPLE cycles, `err_unstable`=1, `sensor_out` = the raw value in the last SAMPLE cycle.
- Reset mid-move: assert `rst` at cycle 10 of an east (0100) move. Required: `motor_en`/`motor_step`=0 from the next edge, no `advance` ever produced, a fresh command accepted normally afterwards.
- Busy ignore: hold `cmd_valid`=1 with changing `cmd_code` throughout a move. Required: `cmd_ready`=0 during MOVE..REPORT, only the first code is executed, and the next accept occurs in the IDLE cycle after REPORT.
